// File: rtl/alif_param_serializer.sv
// Transmit side of the ALIF serial parameter-load link: snapshots the five loader fields and
// streams them MSB-first behind a one-cycle preamble, followed by a load_enable-low gap.
module alif_param_serializer #(
    parameter int FIELD_W    = 8,
    parameter int NUM_FIELDS = 5,
    parameter int GAP_CYCLES = 1
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       enable,
    input  logic       start,
    input  logic       abort,
    input  logic [2:0] weight_a_in,
    input  logic [2:0] weight_b_in,
    input  logic [7:0] leak_rate_in,
    input  logic [7:0] threshold_min_in,
    input  logic [3:0] leak_cycles_in,
    output logic       serial_data_out,
    output logic       load_enable_out,
    output logic       busy,
    output logic       done,
    output logic       aborted
);

    localparam int FRAME_W = FIELD_W * NUM_FIELDS;
    localparam int GAP_W   = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    typedef enum logic [1:0] {
        IDLE,
        PREAMBLE,
        SHIFT,
        GAP
    } state_t;

    state_t             state_reg, state_next;
    logic [2:0]         bit_cnt_reg, bit_cnt_next;
    logic [2:0]         field_cnt_reg, field_cnt_next;
    logic [GAP_W-1:0]   gap_cnt_reg, gap_cnt_next;
    logic [FRAME_W-1:0] shift_reg, shift_next;
    logic               abort_flag_reg, abort_flag_next;
    logic               serial_reg, serial_next;
    logic               load_en_reg, load_en_next;
    logic               busy_reg, busy_next;
    logic               done_reg, done_next;
    logic               aborted_reg, aborted_next;

    logic [FRAME_W-1:0] snapshot;
    logic               last_bit_of_field;
    logic               last_field;

    // Every field occupies a full slot on the wire, zero-extended on the left.
    assign snapshot = {5'b0, weight_a_in, 5'b0, weight_b_in, leak_rate_in,
                       threshold_min_in, 4'b0, leak_cycles_in};

    assign last_bit_of_field = (bit_cnt_reg == 3'(FIELD_W - 1));
    assign last_field        = (field_cnt_reg == 3'(NUM_FIELDS - 1));

    // Outputs are registered from the current state, so they trail the state by one cycle.
    always_comb begin
        state_next      = state_reg;
        bit_cnt_next    = bit_cnt_reg;
        field_cnt_next  = field_cnt_reg;
        gap_cnt_next    = gap_cnt_reg;
        shift_next      = shift_reg;
        abort_flag_next = abort_flag_reg;
        serial_next     = 1'b0;
        load_en_next    = 1'b0;
        busy_next       = 1'b0;
        done_next       = 1'b0;
        aborted_next    = 1'b0;

        case (state_reg)
            IDLE: begin
                if (start && !abort) begin
                    state_next      = PREAMBLE;
                    shift_next      = snapshot;
                    bit_cnt_next    = 3'd0;
                    field_cnt_next  = 3'd0;
                    gap_cnt_next    = '0;
                    abort_flag_next = 1'b0;
                end
            end
            PREAMBLE: begin
                busy_next    = 1'b1;
                load_en_next = 1'b1;
                if (abort) begin
                    state_next      = GAP;
                    abort_flag_next = 1'b1;
                end else begin
                    state_next = SHIFT;
                end
            end
            SHIFT: begin
                busy_next    = 1'b1;
                load_en_next = 1'b1;
                serial_next  = shift_reg[FRAME_W-1];
                shift_next   = {shift_reg[FRAME_W-2:0], 1'b0};
                bit_cnt_next = bit_cnt_reg + 3'd1;
                if (last_bit_of_field) begin
                    field_cnt_next = last_field ? 3'd0 : field_cnt_reg + 3'd1;
                end
                if (abort) begin
                    state_next      = GAP;
                    abort_flag_next = 1'b1;
                end else if (last_bit_of_field && last_field) begin
                    state_next = GAP;
                end
            end
            GAP: begin
                busy_next = 1'b1;
                if (gap_cnt_reg == GAP_W'(GAP_CYCLES - 1)) begin
                    done_next    = !abort_flag_reg;
                    aborted_next = abort_flag_reg;
                    gap_cnt_next = '0;
                    state_next   = IDLE;
                end else begin
                    gap_cnt_next = gap_cnt_reg + GAP_W'(1);
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg      <= IDLE;
            bit_cnt_reg    <= 3'd0;
            field_cnt_reg  <= 3'd0;
            gap_cnt_reg    <= '0;
            shift_reg      <= '0;
            abort_flag_reg <= 1'b0;
            serial_reg     <= 1'b0;
            load_en_reg    <= 1'b0;
            busy_reg       <= 1'b0;
            done_reg       <= 1'b0;
            aborted_reg    <= 1'b0;
        end else if (enable) begin
            state_reg      <= state_next;
            bit_cnt_reg    <= bit_cnt_next;
            field_cnt_reg  <= field_cnt_next;
            gap_cnt_reg    <= gap_cnt_next;
            shift_reg      <= shift_next;
            abort_flag_reg <= abort_flag_next;
            serial_reg     <= serial_next;
            load_en_reg    <= load_en_next;
            busy_reg       <= busy_next;
            done_reg       <= done_next;
            aborted_reg    <= aborted_next;
        end
    end

    assign serial_data_out = serial_reg;
    assign load_enable_out = load_en_reg;
    assign busy            = busy_reg;
    assign done            = done_reg;
    assign aborted         = aborted_reg;

endmodule

// File: tb/tb_alif_param_serializer.sv
// Bench for alif_param_serializer: two instances (gap of 1 and 3) checked every cycle against a
// frame-position reference model, plus directed frame, abort, freeze, ignore and reset scenarios.
module tb_alif_param_serializer;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       enable = 1'b0;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic [2:0] wa = 3'd0;
    logic [2:0] wb = 3'd0;
    logic [7:0] lr = 8'd0;
    logic [7:0] thr = 8'd0;
    logic [3:0] lc = 4'd0;
    logic       sd0, le0, busy0, done0, ab0;
    logic       sd1, le1, busy1, done1, ab1;

    int n_tests = 0;
    int n_fail  = 0;

    // Model: per instance, position within the current frame and its (possibly truncated) length.
    int          gap_of [2] = '{1, 3};
    logic        m_act  [2];
    int          m_pos  [2];
    int          m_nb   [2];
    logic        m_abf  [2];
    logic [39:0] m_snap [2];
    logic [4:0]  m_cur  [2];

    always #5 clk = ~clk;

    alif_param_serializer dut0 (
        .clk(clk), .reset_n(reset_n), .enable(enable), .start(start), .abort(abort),
        .weight_a_in(wa), .weight_b_in(wb), .leak_rate_in(lr), .threshold_min_in(thr),
        .leak_cycles_in(lc), .serial_data_out(sd0), .load_enable_out(le0), .busy(busy0),
        .done(done0), .aborted(ab0)
    );

    alif_param_serializer #(.GAP_CYCLES(3)) dut1 (
        .clk(clk), .reset_n(reset_n), .enable(enable), .start(start), .abort(abort),
        .weight_a_in(wa), .weight_b_in(wb), .leak_rate_in(lr), .threshold_min_in(thr),
        .leak_cycles_in(lc), .serial_data_out(sd1), .load_enable_out(le1), .busy(busy1),
        .done(done1), .aborted(ab1)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Expected {busy, load_en, data, done, aborted} for position pos of a frame.
    function automatic logic [4:0] item(input int pos, input int nb, input int g,
                                        input logic abf, input logic [39:0] snap);
        if (pos == 1)
            return 5'b11000;
        if (pos <= 1 + nb)
            return {2'b11, snap[39 - (pos - 2)], 2'b00};
        if (pos < 1 + nb + g)
            return 5'b10000;
        return {3'b100, !abf, abf};
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_act[k] = 1'b0;
            m_pos[k] = 0;
            m_nb[k]  = 40;
            m_abf[k] = 1'b0;
            m_snap[k] = 40'd0;
            m_cur[k] = 5'd0;
        end
    endtask

    task automatic model_edge(input logic st, input logic ab);
        for (int k = 0; k < 2; k++) begin
            if (!m_act[k]) begin
                m_cur[k] = 5'd0;
                if (st && !ab) begin
                    m_act[k]  = 1'b1;
                    m_pos[k]  = 0;
                    m_nb[k]   = 40;
                    m_abf[k]  = 1'b0;
                    m_snap[k] = {5'd0, wa, 5'd0, wb, lr, thr, 4'd0, lc};
                end
            end else begin
                m_pos[k]++;
                if (ab && m_pos[k] <= 1 + m_nb[k]) begin
                    m_nb[k]  = m_pos[k] - 1;
                    m_abf[k] = 1'b1;
                end
                m_cur[k] = item(m_pos[k], m_nb[k], gap_of[k], m_abf[k], m_snap[k]);
                if (m_pos[k] == 1 + m_nb[k] + gap_of[k])
                    m_act[k] = 1'b0;
            end
        end
    endtask

    task automatic check_outputs();
        check("dut0_outs", {busy0, le0, sd0, done0, ab0}, m_cur[0]);
        check("dut1_outs", {busy1, le1, sd1, done1, ab1}, m_cur[1]);
    endtask

    // Called just after a falling edge; inputs are sampled at the next rising edge.
    task automatic cycle(input logic en, input logic st, input logic ab);
        enable = en;
        start  = st;
        abort  = ab;
        @(posedge clk);
        if (en)
            model_edge(st, ab);
        @(negedge clk);
        check_outputs();
    endtask

    task automatic rand_fields();
        wa  = 3'($urandom);
        wb  = 3'($urandom);
        lr  = 8'($urandom);
        thr = 8'($urandom);
        lc  = 4'($urandom);
    endtask

    task automatic fixed_fields();
        wa = 3'd5; wb = 3'd3; lr = 8'hA5; thr = 8'd40; lc = 4'd9;
    endtask

    task automatic do_reset();
        #2 reset_n = 1'b0;
        #1 check("async_reset", {busy0, le0, sd0, done0, ab0, busy1, le1, sd1, done1, ab1}, 64'd0);
        model_reset();
        @(negedge clk);
        check_outputs();
        reset_n = 1'b1;
    endtask

    localparam logic [63:0] FRAME_STREAM = 64'h05_03A5_2809;

    initial begin
        logic [63:0] stream;
        int          nbits;
        int          done_at;
        int          ab_seen;
        int          done_seen;

        model_reset();
        repeat (2) @(negedge clk);
        check_outputs();
        reset_n = 1'b1;

        // Full frame with the reference values; inputs scrambled after acceptance.
        fixed_fields();
        cycle(1'b1, 1'b1, 1'b0);
        stream = 64'd0; nbits = 0; done_at = -1;
        for (int i = 1; i <= 50; i++) begin
            rand_fields();
            cycle(1'b1, 1'b0, 1'b0);
            if (le0) begin
                stream = {stream[62:0], sd0};
                nbits++;
            end
            if (done0 && done_at < 0)
                done_at = i;
        end
        check("frame_bits", stream, FRAME_STREAM);
        check("frame_len", 64'(nbits), 64'd41);
        check("done_edge", 64'(done_at), 64'd42);
        $display("[TB] full frame: stream=%0h len=%0d done_edge=%0d", stream, nbits, done_at);

        // Abort after 12 SHIFT bits.
        rand_fields();
        cycle(1'b1, 1'b1, 1'b0);
        repeat (12) cycle(1'b1, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 1'b1);
        ab_seen = 0; done_seen = 0;
        for (int i = 0; i < 10; i++) begin
            cycle(1'b1, 1'b0, 1'b0);
            if (ab0) ab_seen++;
            if (done0) done_seen++;
        end
        check("abort_pulse", 64'(ab_seen), 64'd1);
        check("abort_no_done", 64'(done_seen), 64'd0);
        $display("[TB] abort: aborted pulses=%0d done pulses=%0d", ab_seen, done_seen);

        // Enable toggled every other cycle: same stream over enabled cycles.
        fixed_fields();
        cycle(1'b1, 1'b1, 1'b0);
        stream = 64'd0; nbits = 0;
        for (int i = 0; i < 110; i++) begin
            cycle(1'(i % 2), 1'b0, 1'b0);
            if ((i % 2) == 1 && le0) begin
                stream = {stream[62:0], sd0};
                nbits++;
            end
        end
        check("gated_bits", stream, FRAME_STREAM);
        check("gated_len", 64'(nbits), 64'd41);
        $display("[TB] gated frame: stream=%0h len=%0d", stream, nbits);

        // Start while busy and start+abort in IDLE are both ignored.
        rand_fields();
        cycle(1'b1, 1'b1, 1'b0);
        repeat (21) cycle(1'b1, 1'b0, 1'b0);
        cycle(1'b1, 1'b1, 1'b0);
        repeat (30) cycle(1'b1, 1'b0, 1'b0);
        cycle(1'b1, 1'b1, 1'b1);
        repeat (5) cycle(1'b1, 1'b0, 1'b0);
        check("ignored_idle", {busy0, busy1}, 64'd0);
        $display("[TB] ignored starts: busy0=%0b busy1=%0b", busy0, busy1);

        // Start held high: back-to-back frames.
        for (int i = 0; i < 150; i++) begin
            rand_fields();
            cycle(1'b1, 1'b1, 1'b0);
        end
        repeat (10) cycle(1'b1, 1'b0, 1'b0);
        $display("[TB] back-to-back frames done");

        // Reset mid-SHIFT.
        cycle(1'b1, 1'b1, 1'b0);
        repeat (10) cycle(1'b1, 1'b0, 1'b0);
        do_reset();
        repeat (5) cycle(1'b1, 1'b0, 1'b0);
        check("post_reset_idle", {busy0, busy1}, 64'd0);
        $display("[TB] reset mid-shift: busy0=%0b busy1=%0b", busy0, busy1);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            rand_fields();
            cycle(1'($urandom_range(0, 4) != 0), 1'($urandom_range(0, 7) == 0),
                  1'($urandom_range(0, 49) == 0));
            if ($urandom_range(0, 999) == 0)
                do_reset();
        end
        $display("[TB] random traffic: 3000 cycles");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
